hex_display_scanner: RTL and testbench
======================================

// Module: hex_display_scanner
// PURPOSE
//  Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display showing a hex value.
//  Next generation of the 4-digit debug display: adds digit-count and timing parameters,
//  per-digit decimal points, leading-zero blanking, a run-time brightness input,
//  an anti-ghost blanking gap, a load-strobed shadow register and a frame pulse.
//  Sits at the board top level between debug/status registers and the display pins.
// PARAMETERS
//  DIGITS  4       number of digits, 1..8; digit 0 = least significant (rightmost)
//  PERIOD  50_000  clock cycles per digit slot; must be >= BLANK+2
//  BLANK   64      cycles at the start of each slot with every digit off (anti-ghost)
// PORTS
//  clock       in   1         system clock, rising edge
//  reset       in   1         asynchronous, active-high
//  value       in   4*DIGITS  hex value; nibble i -> digit i
//  dp          in   DIGITS    decimal point request per digit, 1 = lit
//  load        in   1         1 = capture value/dp into shadow this cycle
//  blank_lz    in   1         1 = suppress leading zeros
//  brightness  in   8         duty: 0 = off, 255 = always on
//  digit       out  DIGITS    digit enables, active-low
//  segment     out  8         {a,b,c,d,e,f,g,dp}, active-low
//  frame       out  1         one-cycle pulse when the last digit's slot ends
// BEHAVIOUR
//  Reset (asynchronous, immediate): digit = all 1s, segment = 8'hFF, frame = 0,
//   shadow value/dp = 0, slot counter = 0, column = 0, PWM counter = 0.
//  Shadow: load=1 at edge t -> shadow holds value/dp after t. Display reads only the shadow.
//  Slot counter: 0..PERIOD-1, then wraps to 0; on wrap column advances, DIGITS-1 -> 0.
//  frame = 1 for exactly the cycle in which the slot counter wraps with column = DIGITS-1.
//  Segment pattern: registered once per slot, on the cycle the slot counter wraps, from the
//   shadow nibble of the incoming column. Pattern changes take effect only at slot boundaries.
//  load coinciding with a wrap: the pattern is decoded from the pre-load shadow. The new value
//   appears at the following boundary.
//  Hex decode (active-high a..g, before inversion):
//   0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 E6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E.
//   dp bit = shadow dp[column], ORed into bit 0.
//  Leading-zero blanking: digit i > 0 has segments a..g off when blank_lz = 1 and
//   nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked. dp is unaffected by blanking.
//  PWM: free-running 8-bit counter p; pwm_on = (brightness == 255) | (p < brightness).
//  Digit drive: digit[column] = 0 only when slot counter >= BLANK and pwm_on. All other bits = 1.
//   digit is registered, so there is 1 cycle of latency from counter/pwm to pin.
//  Width rule: column is clog2(DIGITS) bits wide (minimum 1). DIGITS = 1 keeps column at 0.
//  brightness and blank_lz are sampled live and need no load.
// STRUCTURE
//  Shared package/header seg7_pkg: 16-entry hex segment constants, SEG_OFF = 8'hFF,
//   and a clog2 function.
//  One sub-module, pwm_gen (8-bit counter plus compare, outputs pwm_on).
//  The hex decode stays inline as a case on the shadow nibble.
// TESTING (bench: DIGITS=4, PERIOD=8, BLANK=2)
//  1. Reset asserted mid-slot -> digit=4'hF, segment=8'hFF the same cycle; frame=0; counters 0.
//  2. load value=16'h12AF, dp=0, brightness=255 -> segments 71(F), 11(A), 25(2), 9F(1)
//     in slots for columns 0,1,2,3; digit[c] low for cycles 2..7 of each slot; frame every 32 cycles.
//  3. value=16'h0050, blank_lz=1 -> digits 3 and 2 show 8'hFF; digit 1 shows 8'h49 (5);
//     digit 0 shows 8'h03 (0). With blank_lz=0, digits 3 and 2 show 8'h03.
//  4. value=0, dp=4'b0100, blank_lz=1 -> digit 2 shows 8'hFE (dp only); digit 0 shows 8'h03.
//  5. brightness=0 -> digit stays 4'hF. brightness=64 -> active digit low for exactly
//     64 of every 256 non-blank cycles.
//  6. load pulsed on the wrap cycle -> the old pattern is kept for that slot and the new
//     pattern appears at the next boundary. value change without load -> no display change.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment display drivers.
//   - SEG_HEX_0..SEG_HEX_F : active-high {a,b,c,d,e,f,g,dp} patterns for hex
//                            digits 0..F. The dp bit is always 0 here; callers
//                            OR in their own decimal point.
//   - SEG_OFF              : active-low pattern with every segment dark.
//   - clog2()              : ceiling log2, used to size counters and indices.
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [7:0] SEG_HEX_0 = 8'hFC;
    localparam logic [7:0] SEG_HEX_1 = 8'h60;
    localparam logic [7:0] SEG_HEX_2 = 8'hDA;
    localparam logic [7:0] SEG_HEX_3 = 8'hF2;
    localparam logic [7:0] SEG_HEX_4 = 8'h66;
    localparam logic [7:0] SEG_HEX_5 = 8'hB6;
    localparam logic [7:0] SEG_HEX_6 = 8'hBE;
    localparam logic [7:0] SEG_HEX_7 = 8'hE0;
    localparam logic [7:0] SEG_HEX_8 = 8'hFE;
    localparam logic [7:0] SEG_HEX_9 = 8'hE6;
    localparam logic [7:0] SEG_HEX_A = 8'hEE;
    localparam logic [7:0] SEG_HEX_B = 8'h3E;
    localparam logic [7:0] SEG_HEX_C = 8'h9C;
    localparam logic [7:0] SEG_HEX_D = 8'h7A;
    localparam logic [7:0] SEG_HEX_E = 8'h9E;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    // Active-low: all segments (and dp) dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Ceiling log2 of n; returns 0 for n <= 1. Callers clamp to a minimum
    // width of 1 where a zero-width vector would be illegal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((32'sd1 << k) < n) begin
                r = k + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_display_scanner_pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
// Brightness PWM for the display scanner. A free-running 8-bit counter is
// compared against the live brightness value.
// Ports:
//   clock       in  1  system clock, rising edge
//   reset       in  1  asynchronous, active-high
//   brightness  in  8  duty: 0 = never on, 255 = always on
//   pwm_on      out 1  combinational compare of the current counter value;
//                      the consumer registers it, so the pin sees one cycle
//                      of latency
// -----------------------------------------------------------------------------
module pwm_gen (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] brightness,
    output logic       pwm_on
);

    logic [7:0] p_r;
    logic       pwm_on_s;

    // Free-running PWM phase counter, wraps 255 -> 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_r <= 8'h00;
        end else begin
            p_r <= p_r + 8'h01;
        end
    end

    // Duty compare; 255 is forced fully on since p < 255 would miss one phase.
    always_comb begin
        pwm_on_s = 1'b0;
        if (brightness == 8'hFF) begin
            pwm_on_s = 1'b1;
        end else begin
            pwm_on_s = (p_r < brightness);
        end
    end

    assign pwm_on = pwm_on_s;

endmodule

// File: rtl/hex_display_scanner.sv
// -----------------------------------------------------------------------------
// hex_display_scanner
// Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display
// showing a hex value, with per-digit decimal points, leading-zero blanking,
// PWM brightness, an anti-ghost blanking gap at the start of every digit slot,
// a load-strobed shadow register and a once-per-frame pulse.
// Parameters:
//   DIGITS  number of digits (1..8), digit 0 is the rightmost
//   PERIOD  clock cycles per digit slot (>= BLANK+2)
//   BLANK   cycles at the start of each slot with all digits off
// Ports:
//   clock       in  1         system clock, rising edge
//   reset       in  1         asynchronous, active-high
//   value       in  4*DIGITS  hex value, nibble i drives digit i
//   dp          in  DIGITS    decimal point request per digit, 1 = lit
//   load        in  1         capture value/dp into the shadow this cycle
//   blank_lz    in  1         suppress leading zeros (live)
//   brightness  in  8         PWM duty (live)
//   digit       out DIGITS    digit enables, active-low, registered
//   segment     out 8         {a,b,c,d,e,f,g,dp}, active-low, registered
//   frame       out 1         high for the cycle the last digit's slot wraps
// -----------------------------------------------------------------------------
module hex_display_scanner
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int PERIOD = 50_000,
    parameter int BLANK  = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [7:0]            brightness,
    output logic [DIGITS-1:0]     digit,
    output logic [7:0]            segment,
    output logic                  frame
);

    localparam int COL_W = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);
    localparam int CNT_W = (clog2(PERIOD) < 1) ? 1 : clog2(PERIOD);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(PERIOD - 2);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    // Registered state
    logic [4*DIGITS-1:0] shadow_val_r;
    logic [DIGITS-1:0]   shadow_dp_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [COL_W-1:0]    col_r;
    logic [7:0]          seg_r;
    logic [DIGITS-1:0]   digit_r;
    logic                frame_r;

    // Combinational helpers
    logic                wrap_s;
    logic [CNT_W-1:0]    cnt_next_s;
    logic [COL_W-1:0]    col_next_s;
    logic [3:0]          nib_s;
    logic                dp_bit_s;
    logic                zero_run_s;
    logic                blank_s;
    logic [7:0]          hex_s;
    logic [7:0]          lit_s;
    logic [7:0]          seg_next_s;
    logic                drive_on_s;
    logic [DIGITS-1:0]   digit_next_s;
    logic                frame_next_s;
    logic                pwm_on_s;

    pwm_gen u_pwm (
        .clock      (clock),
        .reset      (reset),
        .brightness (brightness),
        .pwm_on     (pwm_on_s)
    );

    // Slot counter and column sequencing: next values after this edge.
    always_comb begin
        wrap_s     = (cnt_r == CNT_LAST);
        cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        col_next_s = col_r;
        if (wrap_s) begin
            cnt_next_s = {CNT_W{1'b0}};
            if (col_r == COL_LAST) begin
                col_next_s = {COL_W{1'b0}};
            end else begin
                col_next_s = col_r + {{(COL_W-1){1'b0}}, 1'b1};
            end
        end else begin
            col_next_s = col_r;
        end
    end

    // Pick the incoming column's nibble and dp, and decide leading-zero
    // blanking by scanning from the most significant nibble downwards.
    always_comb begin
        nib_s      = 4'h0;
        dp_bit_s   = 1'b0;
        blank_s    = 1'b0;
        zero_run_s = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s & (shadow_val_r[4*i +: 4] == 4'h0);
            nib_s      = (col_next_s == COL_W'(i)) ? shadow_val_r[4*i +: 4] : nib_s;
            dp_bit_s   = (col_next_s == COL_W'(i)) ? shadow_dp_r[i] : dp_bit_s;
            blank_s    = (col_next_s == COL_W'(i)) ? (blank_lz & zero_run_s & (i != 0)) : blank_s;
        end
    end

    // Hex decode of the incoming nibble (active-high before inversion).
    always_comb begin
        hex_s = 8'h00;
        case (nib_s)
            4'h0:    hex_s = SEG_HEX_0;
            4'h1:    hex_s = SEG_HEX_1;
            4'h2:    hex_s = SEG_HEX_2;
            4'h3:    hex_s = SEG_HEX_3;
            4'h4:    hex_s = SEG_HEX_4;
            4'h5:    hex_s = SEG_HEX_5;
            4'h6:    hex_s = SEG_HEX_6;
            4'h7:    hex_s = SEG_HEX_7;
            4'h8:    hex_s = SEG_HEX_8;
            4'h9:    hex_s = SEG_HEX_9;
            4'hA:    hex_s = SEG_HEX_A;
            4'hB:    hex_s = SEG_HEX_B;
            4'hC:    hex_s = SEG_HEX_C;
            4'hD:    hex_s = SEG_HEX_D;
            4'hE:    hex_s = SEG_HEX_E;
            4'hF:    hex_s = SEG_HEX_F;
            default: hex_s = 8'h00;
        endcase
    end

    // Blanking only darkens a..g; the decimal point survives it.
    always_comb begin
        lit_s = 8'h00;
        if (blank_s) begin
            lit_s = 8'h00;
        end else begin
            lit_s = hex_s;
        end
        seg_next_s = ~(lit_s | {7'b000_0000, dp_bit_s});
    end

    // Digit enables are computed from the counter/column values the pins
    // will sit beside after this edge, so the low window lines up with slot
    // positions BLANK..PERIOD-1; the PWM term is the current phase.
    always_comb begin
        drive_on_s   = (cnt_next_s >= CNT_BLANK) & pwm_on_s;
        digit_next_s = {DIGITS{1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            digit_next_s[i] = (col_next_s == COL_W'(i)) ? ~drive_on_s : 1'b1;
        end
    end

    // frame is registered one cycle early so it is high exactly while the
    // last column's counter sits on its wrapping value.
    always_comb begin
        frame_next_s = 1'b0;
        if ((cnt_r == CNT_PRE) && (col_r == COL_LAST)) begin
            frame_next_s = 1'b1;
        end else begin
            frame_next_s = 1'b0;
        end
    end

    // Shadow register: the display only ever reads these copies.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_val_r <= {(4*DIGITS){1'b0}};
            shadow_dp_r  <= {DIGITS{1'b0}};
        end else if (load) begin
            shadow_val_r <= value;
            shadow_dp_r  <= dp;
        end else begin
            shadow_val_r <= shadow_val_r;
            shadow_dp_r  <= shadow_dp_r;
        end
    end

    // Slot counter and active column.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            col_r <= {COL_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
            col_r <= col_next_s;
        end
    end

    // Output registers; the segment pattern only changes at slot boundaries,
    // decoded from the shadow as it stood before this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_r   <= SEG_OFF;
            digit_r <= {DIGITS{1'b1}};
            frame_r <= 1'b0;
        end else begin
            seg_r   <= wrap_s ? seg_next_s : seg_r;
            digit_r <= digit_next_s;
            frame_r <= frame_next_s;
        end
    end

    assign digit   = digit_r;
    assign segment = seg_r;
    assign frame   = frame_r;

endmodule

// File: tb/tb_hex_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_hex_display_scanner
// Scoreboard bench for hex_display_scanner with DIGITS=4, PERIOD=8, BLANK=2.
// The stimulus process queues one expected record per digit slot (slot number,
// segment pattern, number of low digit cycles, frame expectation); the monitor
// observes every cycle and pops/compares at the end of each slot.
// -----------------------------------------------------------------------------
module tb_hex_display_scanner;

    localparam int DIGITS = 4;
    localparam int PERIOD = 8;
    localparam int BLANK  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [7:0]  brightness = 8'hFF;
    logic [3:0]  digit;
    logic [7:0]  segment;
    logic        frame;

    hex_display_scanner #(.DIGITS(DIGITS), .PERIOD(PERIOD), .BLANK(BLANK)) dut (
        .clock      (clock),
        .reset      (reset),
        .value      (value),
        .dp         (dp),
        .load       (load),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .digit      (digit),
        .segment    (segment),
        .frame      (frame)
    );

    always #5 clock = ~clock;

    // low field: >=0 exact count, -1 ignore, -2 add to PWM window, -3 add and close window
    typedef struct {
        int         slot;
        logic [7:0] seg;
        int         low;
        logic       fr;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;

    // Bench cycle count since reset release (edges seen by the DUT).
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input int s, input logic [7:0] seg, input int low);
        exp_t e;
        e.slot = s;
        e.seg  = seg;
        e.low  = low;
        e.fr   = ((s % 4) == 3);
        q.push_back(e);
    endtask

    // pat = {col3, col2, col1, col0}
    task automatic push_pat(input int first, input int last, input logic [31:0] pat, input int low);
        for (int s = first; s <= last; s++) begin
            push(s, pat[8*(s%4) +: 8], low);
        end
    endtask

    task automatic goto(input int t);
        int guard;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (cyc != t && guard < 4000);
        if (cyc != t) begin
            n_fail++;
            $display("FAIL goto: cycle %0d, expected %0d", cyc, t);
        end
    endtask

    // Monitor state
    logic [7:0] m_seg;
    bit         m_seg_bad;
    bit         m_other_bad;
    bit         m_fbad;
    int         m_low;
    int         m_fcnt;
    int         pwm_acc = 0;

    // Monitor: accumulate per-slot observations, compare at slot end.
    always @(negedge clock) begin : mon
        int   pos;
        int   s;
        int   col;
        exp_t e;
        if (!reset) begin
            pos = cyc % 8;
            s   = cyc / 8;
            col = s % 4;
            if (pos == 0) begin
                m_seg = segment; m_seg_bad = 0; m_other_bad = 0;
                m_fbad = 0; m_low = 0; m_fcnt = 0;
            end
            if (segment !== m_seg) m_seg_bad = 1;
            if ((digit | (4'b0001 << col)) !== 4'hF) m_other_bad = 1;
            if (digit[col] === 1'b0) m_low++;
            if (frame === 1'b1) begin
                m_fcnt++;
                if (pos != 7) m_fbad = 1;
            end
            if (pos == 7) begin
                while (q.size() > 0 && q[0].slot < s) begin
                    e = q.pop_front();
                    n_checks++;
                    n_fail++;
                    $display("FAIL slot_missed: slot %0d never observed, now at slot %0d", e.slot, s);
                end
                if (q.size() > 0 && q[0].slot == s) begin
                    e = q.pop_front();
                    check($sformatf("segment slot %0d col %0d", s, col), {23'd0, m_seg_bad, m_seg}, {23'd0, 1'b0, e.seg});
                    check($sformatf("other_digits slot %0d", s), {31'd0, m_other_bad}, 32'd0);
                    check($sformatf("frame slot %0d", s), {m_fbad, 31'(m_fcnt)}, {1'b0, 31'(e.fr)});
                    if (e.low >= 0) begin
                        check($sformatf("digit_low slot %0d", s), m_low, e.low);
                    end else if (e.low <= -2) begin
                        pwm_acc += m_low;
                        if (e.low == -3) begin
                            check("pwm_64_window", pwm_acc, 192);
                            pwm_acc = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Test 1: run with a value showing, then reset mid-slot.
        value = 16'h12AF; dp = 4'h0; load = 1'b1; blank_lz = 1'b0; brightness = 8'hFF;
        @(posedge clock); #2 reset = 1'b0;
        goto(21);
        check("pre_reset segment", {24'd0, segment}, 32'h25);
        check("pre_reset digit", {28'd0, digit}, 32'hB);
        #2 reset = 1'b1;
        #1;
        check("reset digit", {28'd0, digit}, 32'hF);
        check("reset segment", {24'd0, segment}, 32'hFF);
        check("reset frame", {31'd0, frame}, 32'd0);
        @(posedge clock);

        // Test 2: 12AF at full brightness; load held over release.
        push(0, 8'hFF, 6);
        push_pat(1, 8, 32'h9F25_1171, 6);
        @(posedge clock); #2 reset = 1'b0;
        goto(1);
        load = 1'b0;

        // Test 3: leading-zero blanking on 0050, then off.
        goto(68);
        value = 16'h0050; blank_lz = 1'b1; load = 1'b1;
        goto(69);
        load = 1'b0;
        push_pat(9, 12, 32'hFFFF_4903, 6);
        goto(100);
        blank_lz = 1'b0;
        push_pat(13, 16, 32'h0303_4903, 6);

        // Test 4: all-zero value with dp on digit 2.
        goto(132);
        value = 16'h0000; dp = 4'b0100; blank_lz = 1'b1; load = 1'b1;
        goto(133);
        load = 1'b0;
        push_pat(17, 19, 32'hFFFE_FF03, 6);

        // Test 5: brightness 0, then 64 over a 1024-cycle window.
        goto(164);
        brightness = 8'h00;
        push(20, 8'h03, -1);
        push_pat(21, 23, 32'hFFFE_FF03, 0);
        goto(196);
        brightness = 8'd64;
        push(24, 8'h03, -1);
        push_pat(25, 151, 32'hFFFE_FF03, -2);
        push(152, 8'h03, -3);

        // Test 6: load on the wrap cycle, then value change without load.
        goto(1228);
        brightness = 8'hFF;
        push(153, 8'hFF, -1);
        push_pat(154, 155, 32'hFFFE_FF03, 6);
        goto(1247);
        value = 16'h3C7E; dp = 4'h0; load = 1'b1;
        goto(1248);
        load = 1'b0;
        push(156, 8'h03, 6);
        push_pat(157, 164, 32'h0D63_1F61, 6);
        goto(1252);
        value = 16'hFFFF;

        // Drain the scoreboard (bounded).
        for (int k = 0; k < 200 && q.size() > 0; k++) begin
            @(negedge clock);
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d slots left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
